// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
//  Module      : counter_checker
//  Description : Sequence checker placed behind a free-running counter. It
//                samples the observed count every clock and expects each
//                value to be the previous one plus one (mod 2^WIDTH). It
//                locks onto the sequence, counts wrap-arounds and errors,
//                and offers each counted wrap to a sink over a valid/ready
//                report port.
//  Ports       :
//    clk           in   1       clock, all state changes on posedge
//    rst_n         in   1       asynchronous active-low reset
//    count         in   WIDTH   observed counter value
//    enable        in   1       checking enabled; low returns to IDLE
//    clear         in   1       synchronous clear of wrap/err counts, overrun
//    locked        out  1       high while the checker is locked
//    err_pulse     out  1       one-cycle pulse per detected error
//    err_count     out  ERR_W   saturating error count
//    wrap_count    out  WRAP_W  wraps seen while locked (modulo)
//    report_valid  out  1       report available
//    report_ready  in   1       sink accepts report
//    report_data   out  WRAP_W  wrap_count value at the reported wrap
//    overrun       out  1       sticky: wrap while a report was still pending
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_checker #(
  parameter int WIDTH    = 5,
  parameter int SYNC_LEN = 2,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  count,
  input  logic              enable,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [WRAP_W-1:0] report_data,
  output logic              overrun
);

  // Run counter only needs to reach SYNC_LEN.
  localparam int RUN_W = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);
  localparam logic [RUN_W-1:0] c_SYNC_LEN = RUN_W'(SYNC_LEN);
  localparam logic [ERR_W-1:0] c_ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_prev;
  logic              r_prev_valid;
  logic [RUN_W-1:0]  r_good_run;
  logic              r_locked;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;
  logic [WRAP_W-1:0] r_wrap_count;
  logic              r_report_valid;
  logic [WRAP_W-1:0] r_report_data;
  logic              r_overrun;

  logic [WIDTH-1:0]  w_prev_inc;
  logic [RUN_W-1:0]  w_run_inc;
  logic              w_match;
  logic              w_wrap;
  logic              w_err;
  logic              w_wrap_cnt;
  logic              w_accept;
  logic              w_load;

  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_run_inc  = r_good_run + RUN_W'(1);

  // The very first sample after reset has no predecessor and never matches.
  assign w_match = r_prev_valid && (count == w_prev_inc);
  assign w_wrap  = w_match && (r_prev == {WIDTH{1'b1}}) && (count == '0);

  // Errors and wraps are only recognised while locked and enabled; a low
  // enable suppresses both for that cycle.
  assign w_err      = enable && (r_state == ST_LOCKED) && !w_match;
  assign w_wrap_cnt = enable && (r_state == ST_LOCKED) && w_wrap;

  assign w_accept = r_report_valid && report_ready;
  // A new report may be loaded when the slot is empty or is being drained
  // in this very cycle (back-to-back transfer).
  assign w_load   = w_wrap_cnt && (!r_report_valid || report_ready);

  // --------------------------------------------------------------------------
  // Sequence tracking and lock state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_good_run   <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_prev       <= count;
      r_prev_valid <= 1'b1;
      r_err_pulse  <= w_err;

      if (!enable) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_SYNC;
            r_good_run <= '0;
            r_locked   <= 1'b0;
          end
          ST_SYNC: begin
            if (w_match) begin
              r_good_run <= w_run_inc;
              if (w_run_inc >= c_SYNC_LEN) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good_run <= '0;
            end
          end
          ST_LOCKED: begin
            if (!w_match) begin
              r_state    <= ST_SYNC;
              r_good_run <= '0;
              r_locked   <= 1'b0;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics counters; clear overrides any same-cycle update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_overrun    <= 1'b0;
    end else if (clear) begin
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_err && (r_err_count != c_ERR_MAX)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
      if (w_wrap_cnt) begin
        r_wrap_count <= r_wrap_count + WRAP_W'(1);
      end
      if (w_wrap_cnt && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Report port; independent of clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_report_valid <= 1'b0;
      r_report_data  <= '0;
    end else if (w_load) begin
      r_report_valid <= 1'b1;
      r_report_data  <= r_wrap_count + WRAP_W'(1);
    end else if (w_accept) begin
      r_report_valid <= 1'b0;
    end
  end

  assign locked       = r_locked;
  assign err_pulse    = r_err_pulse;
  assign err_count    = r_err_count;
  assign wrap_count   = r_wrap_count;
  assign report_valid = r_report_valid;
  assign report_data  = r_report_data;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
